dual_lane_forward_stage: RTL and testbench

- Dual-lane pipeline stage register (line1/line2) that sits between two back-end stages of the dual-issue pipeline.
- It holds each lane's pending register writeback and tracks any outstanding memory-returned result.
- It is the producer side of the per-stage forward bus: every cycle it drives {we, waddr, wdata, stall} per lane, which the ID-stage forwarding/relevance logic consumes.
- It guarantees `we` is asserted only for live, legal writes, and `stall` is asserted exactly while the write value is not yet final.

---
 rtl/dual_lane_forward_stage_pkg.sv | 24 ++
 rtl/dual_lane_forward_stage_if.sv | 39 +++
 rtl/dual_lane_forward_stage_forward_lane_slot.sv | 88 ++++++++
 rtl/dual_lane_forward_stage.sv | 62 ++++++
 tb/tb_dual_lane_forward_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_lane_forward_stage_pkg.sv
// Shared constants, lane indices, slot state encoding and forward-bus entry layout
// for the dual-lane forward stage.
package dual_lane_forward_stage_pkg;
  localparam int DFS_DATA_W = 32;
  localparam int DFS_ADDR_W = 5;
  localparam int NUM_LANES  = 2;
  localparam int LINE1      = 0;
  localparam int LINE2      = 1;
  localparam int FWD_W      = 1 + DFS_ADDR_W + DFS_DATA_W + 1;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_WAIT  = 2'd1,
    SLOT_READY = 2'd2
  } slot_state_e;

  // One forward-bus entry, MSB first: {we, waddr, wdata, stall}
  typedef struct packed {
    logic                  we;
    logic [DFS_ADDR_W-1:0] waddr;
    logic [DFS_DATA_W-1:0] wdata;
    logic                  stall;
  } fwd_entry_t;
endpackage

// File: rtl/dual_lane_forward_stage_if.sv
// Handshake, response and forward-bus signals of the dual-lane forward stage.
// slave = the stage itself, master = the surrounding pipeline (or a bench).
interface dual_lane_forward_stage_if
  import dual_lane_forward_stage_pkg::*;
#(
  parameter int DATA_W = DFS_DATA_W,
  parameter int ADDR_W = DFS_ADDR_W
);
  logic                                         flush;
  logic                                         in_valid;
  logic                                         in_allowin;
  logic [NUM_LANES-1:0]                         in_lane_v;
  logic [NUM_LANES-1:0]                         in_we;
  logic [NUM_LANES-1:0][ADDR_W-1:0]             in_waddr;
  logic [NUM_LANES-1:0][DATA_W-1:0]             in_wdata;
  logic [NUM_LANES-1:0]                         in_wait_data;
  logic [NUM_LANES-1:0]                         in_late;
  logic                                         resp_valid;
  logic                                         resp_lane;
  logic [DATA_W-1:0]                            resp_data;
  logic                                         out_valid;
  logic                                         out_allowin;
  logic [NUM_LANES-1:0]                         out_we;
  logic [NUM_LANES-1:0][ADDR_W-1:0]             out_waddr;
  logic [NUM_LANES-1:0][DATA_W-1:0]             out_wdata;
  logic [NUM_LANES-1:0][ADDR_W+DATA_W+1:0]      fwd_obus;

  modport slave (
    input  flush, in_valid, in_lane_v, in_we, in_waddr, in_wdata, in_wait_data, in_late,
    input  resp_valid, resp_lane, resp_data, out_allowin,
    output in_allowin, out_valid, out_we, out_waddr, out_wdata, fwd_obus
  );

  modport master (
    output flush, in_valid, in_lane_v, in_we, in_waddr, in_wdata, in_wait_data, in_late,
    output resp_valid, resp_lane, resp_data, out_allowin,
    input  in_allowin, out_valid, out_we, out_waddr, out_wdata, fwd_obus
  );
endinterface

// File: rtl/dual_lane_forward_stage_forward_lane_slot.sv
// One lane of the stage: EMPTY/WAIT/READY slot, result latch and stale-response drop counter.
// FWD_RESP_BYPASS_EN: a matching response is visible on wdata/pending in its own cycle.
module forward_lane_slot
  import dual_lane_forward_stage_pkg::*;
#(
  parameter int DATA_W = DFS_DATA_W,
  parameter int ADDR_W = DFS_ADDR_W,
  parameter int DROP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              capture,
  input  logic              handoff,
  input  logic              cap_lane_v,
  input  logic              cap_we,
  input  logic              cap_wait,
  input  logic              cap_late,
  input  logic [ADDR_W-1:0] cap_waddr,
  input  logic [DATA_W-1:0] cap_wdata,
  input  logic              resp_hit,
  input  logic [DATA_W-1:0] resp_data,
  output logic              lane_v,
  output logic              we,
  output logic              late,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              pending
);
  slot_state_e       state, state_nxt;
  logic [DROP_W-1:0] drop;
  logic [DATA_W-1:0] wdata_q;
  logic              match, is_wait, cap_w, cap_hit, inc, dec;

  assign match   = resp_hit && (drop == '0);
  assign is_wait = (state == SLOT_WAIT);
  assign cap_w   = cap_lane_v && cap_wait;
  // a response only belongs to the incoming instruction if the old one is not still waiting for it
  assign cap_hit = match && !is_wait;
  assign inc     = flush && is_wait && !match;
  assign dec     = resp_hit && (drop != '0);

  always_comb begin
    state_nxt = state;
    if (flush)                 state_nxt = SLOT_EMPTY;
    else if (capture)          state_nxt = (cap_w && !cap_hit) ? SLOT_WAIT : SLOT_READY;
    else if (handoff)          state_nxt = SLOT_EMPTY;
    else if (is_wait && match) state_nxt = SLOT_READY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_v  <= 1'b0;
      we      <= 1'b0;
      late    <= 1'b0;
      waddr   <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      lane_v  <= cap_lane_v;
      we      <= cap_we;
      late    <= cap_late;
      waddr   <= cap_waddr;
      wdata_q <= (cap_w && cap_hit) ? resp_data : cap_wdata;
    end else if (is_wait && match) begin
      wdata_q <= resp_data;
    end
  end

  // one outstanding request is orphaned per waiting flush; its response is discarded later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           drop <= '0;
    else if (inc && !dec && drop != '1)   drop <= drop + 1'b1;
    else if (dec && !inc)                 drop <= drop - 1'b1;
  end

`ifdef FWD_RESP_BYPASS_EN
  assign pending = is_wait && !match;
  assign wdata   = (is_wait && match) ? resp_data : wdata_q;
`else
  assign pending = is_wait;
  assign wdata   = wdata_q;
`endif
endmodule

// File: rtl/dual_lane_forward_stage.sv
// Dual-lane back-end stage register producing the per-stage forward bus.
// Optional FWD_RESP_BYPASS_EN (inside the lane slots) lets a response release the stage same-cycle.
module dual_lane_forward_stage
  import dual_lane_forward_stage_pkg::*;
#(
  parameter int DATA_W = DFS_DATA_W,
  parameter int ADDR_W = DFS_ADDR_W,
  parameter int DROP_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dual_lane_forward_stage_if.slave  bus
);
  logic                             valid, ready_go, capture, handoff;
  logic [NUM_LANES-1:0]             lane_v, we, late, pending, wr_ok;
  logic [NUM_LANES-1:0][ADDR_W-1:0] waddr;
  logic [NUM_LANES-1:0][DATA_W-1:0] wdata;

  assign ready_go       = ~|(lane_v & pending);
  assign bus.in_allowin = !valid || (ready_go && bus.out_allowin);
  assign bus.out_valid  = valid && ready_go && !bus.flush;
  assign capture        = bus.in_valid && bus.in_allowin && !bus.flush;
  assign handoff        = bus.out_valid && bus.out_allowin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         valid <= 1'b0;
    else if (bus.flush) valid <= 1'b0;
    else if (capture)   valid <= 1'b1;
    else if (handoff)   valid <= 1'b0;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    forward_lane_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush),
      .capture   (capture),
      .handoff   (handoff),
      .cap_lane_v(bus.in_lane_v[i]),
      .cap_we    (bus.in_we[i]),
      .cap_wait  (bus.in_wait_data[i]),
      .cap_late  (bus.in_late[i]),
      .cap_waddr (bus.in_waddr[i]),
      .cap_wdata (bus.in_wdata[i]),
      .resp_hit  (bus.resp_valid && (bus.resp_lane == 1'(i))),
      .resp_data (bus.resp_data),
      .lane_v    (lane_v[i]),
      .we        (we[i]),
      .late      (late[i]),
      .waddr     (waddr[i]),
      .wdata     (wdata[i]),
      .pending   (pending[i])
    );

    // r0 and invalid/killed lanes never claim a write
    assign wr_ok[i]         = valid && lane_v[i] && we[i] && (waddr[i] != '0);
    assign bus.out_we[i]    = wr_ok[i];
    assign bus.out_waddr[i] = waddr[i];
    assign bus.out_wdata[i] = wdata[i];
    assign bus.fwd_obus[i]  = {wr_ok[i], waddr[i], wdata[i], wr_ok[i] && (pending[i] || late[i])};
  end
endmodule

// File: tb/tb_dual_lane_forward_stage.sv
// Bench for dual_lane_forward_stage: directed vector table, hand sequences for corner cases,
// then random traffic against a reference model (honours FWD_RESP_BYPASS_EN).
module tb_dual_lane_forward_stage;
  import dual_lane_forward_stage_pkg::*;

`ifdef FWD_RESP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_lane_forward_stage_if bus ();
  dual_lane_forward_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic fwd_entry_t fe(input int i);
    return fwd_entry_t'(bus.fwd_obus[i]);
  endfunction

  function automatic logic [1:0] fwd_we();
    return {fe(1).we, fe(0).we};
  endfunction

  function automatic logic [1:0] fwd_st();
    return {fe(1).stall, fe(0).stall};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic oa);
    bus.flush = 1'b0;  bus.in_valid = 1'b0;  bus.in_lane_v = '0;  bus.in_we = '0;
    bus.in_wait_data = '0;  bus.in_late = '0;  bus.in_waddr = '0;  bus.in_wdata = '0;
    bus.resp_valid = 1'b0;  bus.resp_lane = 1'b0;  bus.resp_data = '0;  bus.out_allowin = oa;
  endtask

  typedef struct {
    logic        fl, iv;
    logic [1:0]  lv, we, wt, lt;
    logic [4:0]  a1, a2;
    logic [31:0] d1, rd;
    logic        rv, rl, oa;
    logic        e_ov, e_ia;
    logic [1:0]  e_we, e_st;
    logic [31:0] e_d1;
  } vec_t;

  vec_t tbl[12];

  task automatic apply(input vec_t v);
    bus.flush = v.fl;  bus.in_valid = v.iv;  bus.in_lane_v = v.lv;  bus.in_we = v.we;
    bus.in_wait_data = v.wt;  bus.in_late = v.lt;
    bus.in_waddr = {v.a2, v.a1};
    bus.in_wdata = {v.d1 + 32'h11, v.d1};
    bus.resp_valid = v.rv;  bus.resp_lane = v.rl;  bus.resp_data = v.rd;  bus.out_allowin = v.oa;
  endtask

  // reference model state
  bit          m_valid;
  bit   [1:0]  m_lv, m_we, m_late, m_pend;
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_drop [2];

  initial begin
    // fl iv lv we wt lt a1 a2 d1 rd rv rl oa | ov ia we st d1
    tbl[0]  = '{1'b0,1'b1,2'b11,2'b11,2'b00,2'b00,5'd4,5'd0,32'h11,32'h0,1'b0,1'b0,1'b1, 1'b0,1'b1,2'b00,2'b00,32'h0};
    tbl[1]  = '{1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0,1'b1, 1'b1,1'b1,2'b01,2'b00,32'h11};
    tbl[2]  = '{1'b0,1'b1,2'b01,2'b01,2'b01,2'b00,5'd6,5'd0,32'h0,32'h0,1'b0,1'b0,1'b1, 1'b0,1'b1,2'b00,2'b00,32'h0};
    tbl[3]  = '{1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0,1'b1, 1'b0,1'b0,2'b01,2'b01,32'h0};
    tbl[4]  = '{1'b1,1'b1,2'b01,2'b01,2'b00,2'b00,5'd9,5'd0,32'h33,32'h0,1'b0,1'b0,1'b1, 1'b0,1'b0,2'b01,2'b01,32'h0};
    tbl[5]  = '{1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0,1'b1, 1'b0,1'b1,2'b00,2'b00,32'h0};
    tbl[6]  = '{1'b0,1'b1,2'b11,2'b11,2'b01,2'b10,5'd6,5'd3,32'h44,32'h0,1'b0,1'b0,1'b0, 1'b0,1'b1,2'b00,2'b00,32'h0};
    tbl[7]  = '{1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'hBAD,1'b1,1'b0,1'b0, 1'b0,1'b0,2'b11,2'b11,32'h0};
    tbl[8]  = '{1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h600D,1'b1,1'b0,1'b0, BYP,1'b0,2'b11,{1'b1,~BYP},32'h600D};
    tbl[9]  = '{1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0,1'b0, 1'b1,1'b0,2'b11,2'b10,32'h600D};
    tbl[10] = '{1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0,1'b1, 1'b1,1'b1,2'b11,2'b10,32'h600D};
    tbl[11] = '{1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,5'd0,5'd0,32'h0,32'h0,1'b0,1'b0,1'b1, 1'b0,1'b1,2'b00,2'b00,32'h0};

    idle(1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst.out_valid", bus.out_valid, 1'b0);
    chk("rst.in_allowin", bus.in_allowin, 1'b1);
    chk("rst.fwd_obus", bus.fwd_obus, '0);
    chk("rst.out_we", bus.out_we, '0);
    rst_n = 1'b1;
    tick();

    // directed vector table: capture/r0, wait+flush+capture, stale drop, late lane
    for (int k = 0; k < 12; k++) begin
      apply(tbl[k]);
      #1;
      chk($sformatf("tbl%0d.out_valid", k), bus.out_valid, tbl[k].e_ov);
      chk($sformatf("tbl%0d.in_allowin", k), bus.in_allowin, tbl[k].e_ia);
      chk($sformatf("tbl%0d.out_we", k), bus.out_we, tbl[k].e_we);
      chk($sformatf("tbl%0d.fwd_we", k), fwd_we(), tbl[k].e_we);
      chk($sformatf("tbl%0d.fwd_stall", k), fwd_st(), tbl[k].e_st);
      if (tbl[k].e_we[0] && !tbl[k].e_st[0])
        chk($sformatf("tbl%0d.fwd_wdata1", k), fe(0).wdata, tbl[k].e_d1);
      if (tbl[k].e_we[0])
        chk($sformatf("tbl%0d.fwd_waddr1", k), fe(0).waddr, (k == 1) ? 64'd4 : 64'd6);
      tick();
    end

    // late lane held by downstream back-pressure, then handoff with same-cycle capture
    idle(1'b0);
    bus.in_valid = 1'b1;  bus.in_lane_v = 2'b01;  bus.in_we = 2'b01;  bus.in_late = 2'b01;
    bus.in_waddr = {5'd0, 5'd3};  bus.in_wdata = {32'h0, 32'h77};
    tick();
    bus.in_late = 2'b00;  bus.in_waddr = {5'd0, 5'd5};  bus.in_wdata = {32'h0, 32'h55};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("late.stall", fe(0).stall, 1'b1);
      chk("late.in_allowin", bus.in_allowin, 1'b0);
      chk("late.out_valid", bus.out_valid, 1'b1);
      tick();
    end
    bus.out_allowin = 1'b1;
    #1;
    chk("late.release_allowin", bus.in_allowin, 1'b1);
    chk("late.release_waddr", bus.out_waddr[0], 5'd3);
    tick();
    idle(1'b1);
    #1;
    chk("late.next_waddr", fe(0).waddr, 5'd5);
    chk("late.next_wdata", fe(0).wdata, 32'h55);
    chk("late.next_stall", fe(0).stall, 1'b0);
    tick();
    tick();

    // line2 waits for a memory result delivered after three stalled cycles
    idle(1'b0);
    bus.in_valid = 1'b1;  bus.in_lane_v = 2'b10;  bus.in_we = 2'b10;  bus.in_wait_data = 2'b10;
    bus.in_waddr = {5'd7, 5'd0};
    tick();
    idle(1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wait.stall", fe(1).stall, 1'b1);
      chk("wait.out_valid", bus.out_valid, 1'b0);
      tick();
    end
    bus.resp_valid = 1'b1;  bus.resp_lane = 1'b1;  bus.resp_data = 32'hDEAD;
    #1;
    chk("wait.resp_stall", fe(1).stall, !BYP);
    chk("wait.resp_out_valid", bus.out_valid, BYP);
    if (BYP) chk("wait.resp_bypass_wdata", fe(1).wdata, 32'hDEAD);
    tick();
    idle(1'b0);
    #1;
    chk("wait.done_stall", fe(1).stall, 1'b0);
    chk("wait.done_wdata", fe(1).wdata, 32'hDEAD);
    chk("wait.done_waddr", fe(1).waddr, 5'd7);
    chk("wait.done_out_valid", bus.out_valid, 1'b1);
    bus.out_allowin = 1'b1;
    tick();
    tick();

    // asynchronous reset while line1 waits; the orphaned response must be ignored
    idle(1'b0);
    bus.in_valid = 1'b1;  bus.in_lane_v = 2'b01;  bus.in_we = 2'b01;  bus.in_wait_data = 2'b01;
    bus.in_waddr = {5'd0, 5'd2};
    tick();
    idle(1'b0);
    #1;
    chk("rstw.stall_before", fe(0).stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstw.out_valid", bus.out_valid, 1'b0);
    chk("rstw.in_allowin", bus.in_allowin, 1'b1);
    chk("rstw.fwd_obus", bus.fwd_obus, '0);
    chk("rstw.out_wdata", bus.out_wdata, '0);
    tick();
    rst_n = 1'b1;
    bus.resp_valid = 1'b1;  bus.resp_lane = 1'b0;  bus.resp_data = 32'hEE;
    tick();
    idle(1'b1);
    #1;
    chk("rstw.resp_ignored", bus.fwd_obus, '0);
    chk("rstw.out_valid_after", bus.out_valid, 1'b0);
    chk("rstw.out_wdata_after", bus.out_wdata, '0);
    tick();

    // random traffic against the reference model (DUT is empty with no drops here)
    m_valid = 1'b0;  m_lv = '0;  m_we = '0;  m_late = '0;  m_pend = '0;
    for (int i = 0; i < 2; i++) begin m_addr[i] = '0; m_data[i] = '0; m_drop[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      logic [1:0]  hit, pe, fwe, st;
      logic [31:0] de [2];
      logic        rdy, ia, ov, cap, ho;
      bus.flush        = ($urandom_range(15) == 0);
      bus.in_valid     = 1'($urandom_range(1));
      bus.in_lane_v    = 2'($urandom_range(3));
      bus.in_we        = 2'($urandom_range(3));
      bus.in_wait_data = {($urandom_range(2) == 0), ($urandom_range(2) == 0)};
      bus.in_late      = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
      bus.in_waddr     = {5'($urandom_range(7)), 5'($urandom_range(7))};
      bus.in_wdata     = {$urandom(), $urandom()};
      bus.resp_valid   = ($urandom_range(2) == 0);
      bus.resp_lane    = 1'($urandom_range(1));
      bus.resp_data    = $urandom();
      bus.out_allowin  = ($urandom_range(3) != 0);
      #1;
      for (int i = 0; i < 2; i++) begin
        hit[i] = bus.resp_valid && (bus.resp_lane == 1'(i)) && (m_drop[i] == 0);
        pe[i]  = m_pend[i] && !(BYP && hit[i]);
        de[i]  = (BYP && m_pend[i] && hit[i]) ? bus.resp_data : m_data[i];
        fwe[i] = m_valid && m_lv[i] && m_we[i] && (m_addr[i] != 5'd0);
        st[i]  = fwe[i] && (pe[i] || m_late[i]);
      end
      rdy = (pe == 2'b00);
      ia  = !m_valid || (rdy && bus.out_allowin);
      ov  = m_valid && rdy && !bus.flush;
      chk("rnd.out_valid", bus.out_valid, ov);
      chk("rnd.in_allowin", bus.in_allowin, ia);
      chk("rnd.out_we", bus.out_we, fwe);
      chk("rnd.fwd_we", fwd_we(), fwe);
      chk("rnd.fwd_stall", fwd_st(), st);
      for (int i = 0; i < 2; i++) begin
        if (fwe[i]) begin
          chk("rnd.fwd_waddr", fe(i).waddr, m_addr[i]);
          chk("rnd.out_waddr", bus.out_waddr[i], m_addr[i]);
          if (!st[i]) chk("rnd.fwd_wdata", fe(i).wdata, de[i]);
          if (ov)     chk("rnd.out_wdata", bus.out_wdata[i], de[i]);
        end
      end
      cap = bus.in_valid && ia && !bus.flush;
      ho  = ov && bus.out_allowin;
      for (int i = 0; i < 2; i++) begin
        logic dec, inc, old_pend, w;
        old_pend = m_pend[i];
        dec = bus.resp_valid && (bus.resp_lane == 1'(i)) && (m_drop[i] > 0);
        inc = bus.flush && old_pend && !hit[i];
        if (inc && !dec && m_drop[i] < 3) m_drop[i]++;
        else if (dec && !inc)             m_drop[i]--;
        if (bus.flush) m_pend[i] = 1'b0;
        else if (cap) begin
          m_lv[i] = bus.in_lane_v[i];  m_we[i] = bus.in_we[i];  m_late[i] = bus.in_late[i];
          m_addr[i] = bus.in_waddr[i];  m_data[i] = bus.in_wdata[i];
          w = bus.in_lane_v[i] && bus.in_wait_data[i];
          if (w && hit[i] && !old_pend) begin m_pend[i] = 1'b0; m_data[i] = bus.resp_data; end
          else m_pend[i] = w;
        end
        else if (ho) m_pend[i] = 1'b0;
        else if (old_pend && hit[i]) begin m_pend[i] = 1'b0; m_data[i] = bus.resp_data; end
      end
      if (bus.flush) m_valid = 1'b0;
      else if (cap)  m_valid = 1'b1;
      else if (ho)   m_valid = 1'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
